// File: rtl/pkt_receiver.sv
// pkt_receiver: RX-side packet engine between the TCP/IP stack RX interfaces and the user kernel.
//
// Turns one stack notification at a time into a series of read requests of at most
// MAX_READ_LEN bytes. It then forwards each requested chunk as a user packet
// {size, tlast, tdata}, which the TX packet sender accepts as-is.
//
// Ports:
//   clk, rst                        sole clock, synchronous active-high reset
//   s_axis_notifications_*          88-bit notification: [15:0] session, [31:16] length,
//                                   [63:32] IP, [79:64] port, [80] closed
//   m_axis_read_package_*           read request {length[31:16], session[15:0]}
//   s_axis_rx_metadata_*            16-bit session of the incoming data (consumed, not checked)
//   s_axis_rx_data_*                512-bit data beats; TKEEP is ignored
//   pkt_tx_*                        {size[SIZE_WIDTH-1:0], tlast, tdata[511:0]} user packet beats
//
// Optional feature macro PKT_RECEIVER_STATS_EN adds the 32-bit wrapping counters
// stat_pkt_cnt, stat_beat_cnt and stat_drop_cnt.
module pkt_receiver #(
   parameter logic [15:0] MAX_READ_LEN = 16'd4096,
   parameter int          SIZE_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [87:0]           s_axis_notifications_TDATA,
   input  logic                  s_axis_notifications_TVALID,
   output logic                  s_axis_notifications_TREADY,
   output logic [31:0]           m_axis_read_package_TDATA,
   output logic                  m_axis_read_package_TVALID,
   input  logic                  m_axis_read_package_TREADY,
   input  logic [15:0]           s_axis_rx_metadata_TDATA,
   input  logic                  s_axis_rx_metadata_TVALID,
   output logic                  s_axis_rx_metadata_TREADY,
   input  logic [511:0]          s_axis_rx_data_TDATA,
   input  logic [63:0]           s_axis_rx_data_TKEEP,
   input  logic                  s_axis_rx_data_TLAST,
   input  logic                  s_axis_rx_data_TVALID,
   output logic                  s_axis_rx_data_TREADY,
   output logic [SIZE_WIDTH+512:0] pkt_tx_TDATA,
   output logic                  pkt_tx_TVALID,
   input  logic                  pkt_tx_TREADY
`ifdef PKT_RECEIVER_STATS_EN
   ,
   output logic [31:0]           stat_pkt_cnt,
   output logic [31:0]           stat_beat_cnt,
   output logic [31:0]           stat_drop_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, META, DATA} state_t;

   state_t      state_q, state_d;
   logic [15:0] remaining_q, remaining_d;
   logic [15:0] session_q, session_d;
   logic [15:0] chunk_q, chunk_d;
   logic [15:0] rem_left;
   logic [15:0] notif_sess, notif_len;
   logic        notif_closed, notif_drop;
   logic        notif_hs, rp_hs, meta_hs, beat_hs, last_hs, in_data;
   logic        unused_ok;

   function automatic logic [15:0] clip(input logic [15:0] v);
      return (v < MAX_READ_LEN) ? v : MAX_READ_LEN;
   endfunction

   assign notif_sess   = s_axis_notifications_TDATA[15:0];
   assign notif_len    = s_axis_notifications_TDATA[31:16];
   assign notif_closed = s_axis_notifications_TDATA[80];
   assign notif_drop   = notif_closed || (notif_len == 16'd0);

   // IP, port, metadata session and TKEEP carry nothing this block acts on
   assign unused_ok = ^{s_axis_notifications_TDATA[79:32], s_axis_notifications_TDATA[87:81],
                        s_axis_rx_metadata_TDATA, s_axis_rx_data_TKEEP};

   // All handshake outputs are forced low while rst is held so the reset values are 0
   assign s_axis_notifications_TREADY = !rst && (state_q == IDLE);
   assign m_axis_read_package_TVALID  = !rst && (state_q == REQ);
   assign m_axis_read_package_TDATA   = {chunk_q, session_q};
   assign s_axis_rx_metadata_TREADY   = !rst && (state_q == META);
   assign in_data                     = !rst && (state_q == DATA);
   assign s_axis_rx_data_TREADY       = in_data && pkt_tx_TREADY;
   assign pkt_tx_TVALID               = in_data && s_axis_rx_data_TVALID;
   assign pkt_tx_TDATA                = {SIZE_WIDTH'(chunk_q), s_axis_rx_data_TLAST, s_axis_rx_data_TDATA};

   assign notif_hs = s_axis_notifications_TREADY && s_axis_notifications_TVALID;
   assign rp_hs    = m_axis_read_package_TVALID && m_axis_read_package_TREADY;
   assign meta_hs  = s_axis_rx_metadata_TREADY && s_axis_rx_metadata_TVALID;
   assign beat_hs  = pkt_tx_TVALID && pkt_tx_TREADY;
   assign last_hs  = beat_hs && s_axis_rx_data_TLAST;

   // Saturating subtract guards against a chunk larger than what is left
   assign rem_left = (remaining_q > chunk_q) ? remaining_q - chunk_q : 16'd0;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      session_d   = session_q;
      chunk_d     = chunk_q;
      case (state_q)
         IDLE: if (notif_hs && !notif_drop) begin
            session_d   = notif_sess;
            remaining_d = notif_len;
            chunk_d     = clip(notif_len);
            state_d     = REQ;
         end
         REQ:  state_d = rp_hs ? META : REQ;
         META: state_d = meta_hs ? DATA : META;
         DATA: if (last_hs) begin
            remaining_d = rem_left;
            chunk_d     = clip(rem_left);
            state_d     = (rem_left != 16'd0) ? REQ : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         session_q   <= '0;
         chunk_q     <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         session_q   <= session_d;
         chunk_q     <= chunk_d;
      end
   end

`ifdef PKT_RECEIVER_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_pkt_cnt  <= '0;
         stat_beat_cnt <= '0;
         stat_drop_cnt <= '0;
      end else begin
         stat_pkt_cnt  <= stat_pkt_cnt + 32'(last_hs);
         stat_beat_cnt <= stat_beat_cnt + 32'(beat_hs);
         stat_drop_cnt <= stat_drop_cnt + 32'(notif_hs && notif_drop);
      end
   end
`endif

endmodule
